// File: rtl/spill_register_chain.sv
// Chain of NumStages two-entry spill stages; cuts valid, ready and data paths at every stage.
// Latency: NumStages cycles per item with no stall; Bypass=1 gives a zero-latency wire.
// Backpressure: each stage absorbs up to two items, so ready_o drops after 2*NumStages stalled accepts.
module spill_register_chain #(
    parameter type T              = logic,
    parameter int  NumStages      = 1,
    parameter bit  Bypass         = 1'b0,
    parameter int  UsageW         = $clog2(2*NumStages+1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  T                  data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output T                  data_o,
    output logic [UsageW-1:0] usage_o
);

    if (Bypass) begin : g_bypass
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;

        // Clock, reset and flush have no role in the pass-through path.
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, flush_i};
    end else begin : g_chain
        if (NumStages < 1) begin : g_bad_stages
            $error("spill_register_chain: NumStages must be >= 1");
        end

        // Boundary k sits in front of stage k; boundary NumStages is the module output.
        logic [NumStages:0]   v;
        logic [NumStages:0]   r;
        T                     d [NumStages+1];
        logic [NumStages-1:0] a_full;
        logic [NumStages-1:0] b_full;

        assign v[0]         = valid_i;
        assign d[0]         = data_i;
        assign ready_o      = r[0];
        assign valid_o      = v[NumStages];
        assign data_o       = d[NumStages];
        assign r[NumStages] = ready_i;

        for (genvar s = 0; s < NumStages; s++) begin : g_stage
            logic a_full_q;
            logic b_full_q;
            T     a_data;
            T     b_data;
            logic a_fill;
            logic a_drain;
            logic b_fill;
            logic b_drain;

            assign a_full[s] = a_full_q;
            assign b_full[s] = b_full_q;

            // A always empties when B is free: downstream if it is ready, otherwise into B.
            assign a_fill  = v[s] & r[s] & !flush_i;
            assign a_drain = a_full_q & !b_full_q;
            assign b_fill  = a_drain & !r[s+1] & !flush_i;
            assign b_drain = b_full_q & r[s+1];

            assign r[s]   = (!a_full_q | !b_full_q) & !flush_i;
            assign v[s+1] = (a_full_q | b_full_q) & !flush_i;
            assign d[s+1] = b_full_q ? b_data : a_data;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_full_q <= 1'b0;
                    b_full_q <= 1'b0;
                    a_data   <= '0;
                    b_data   <= '0;
                end else begin
                    if (flush_i) begin
                        a_full_q <= 1'b0;
                        b_full_q <= 1'b0;
                    end else begin
                        if (a_fill | a_drain) a_full_q <= a_fill;
                        if (b_fill | b_drain) b_full_q <= b_fill;
                    end
                    if (a_fill) a_data <= d[s];
                    if (b_fill) b_data <= a_data;
                end
            end
        end

        always_comb begin
            usage_o = '0;
            for (int s = 0; s < NumStages; s++) begin
                usage_o = usage_o + UsageW'(a_full[s]) + UsageW'(b_full[s]);
            end
        end
    end

endmodule

// File: tb/tb_spill_register_chain.sv
// Bench for spill_register_chain: two registered chains (2 and 3 stages) against a queue-per-stage
// model, plus a bypass instance checked as a wire.
module tb_spill_register_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    // Index 0 drives the 2-stage chain, index 1 the 3-stage chain.
    logic       vi [2];
    logic       ri [2];
    logic       fl [2];
    logic [7:0] di [2];

    logic       vo2, ro2, vo3, ro3;
    logic [7:0] do2, do3;
    logic [2:0] us2, us3;

    logic       vib, rib, flb;
    logic [7:0] dib;
    logic       vob, rob;
    logic [7:0] dob;
    logic [1:0] usb;

    int n_tests = 0;
    int n_fail  = 0;

    spill_register_chain #(.T(logic [7:0]), .NumStages(2), .Bypass(1'b0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]),
        .valid_i(vi[0]), .ready_o(ro2), .data_i(di[0]),
        .valid_o(vo2), .ready_i(ri[0]), .data_o(do2), .usage_o(us2));

    spill_register_chain #(.T(logic [7:0]), .NumStages(3), .Bypass(1'b0)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]),
        .valid_i(vi[1]), .ready_o(ro3), .data_i(di[1]),
        .valid_o(vo3), .ready_i(ri[1]), .data_o(do3), .usage_o(us3));

    spill_register_chain #(.T(logic [7:0]), .NumStages(1), .Bypass(1'b1)) dutb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flb),
        .valid_i(vib), .ready_o(rob), .data_i(dib),
        .valid_o(vob), .ready_i(rib), .data_o(dob), .usage_o(usb));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every stage is a little FIFO holding at most two items.
    int         cnt [2][3];
    logic [7:0] itm [2][3][2];

    function automatic int ns(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic model_step(input int i);
        int         n;
        logic [7:0] fr [3];
        bit         x  [4];
        bit         upv, dnr;
        n = ns(i);
        if (fl[i]) begin
            for (int s = 0; s < 3; s++) cnt[i][s] = 0;
        end else begin
            for (int s = 0; s < n; s++) fr[s] = itm[i][s][0];
            for (int s = 0; s <= n; s++) begin
                upv  = (s == 0) ? bit'(vi[i]) : (cnt[i][s-1] > 0);
                dnr  = (s == n) ? bit'(ri[i]) : (cnt[i][s] < 2);
                x[s] = upv && dnr;
            end
            for (int s = 0; s < n; s++) begin
                if (x[s+1]) begin
                    itm[i][s][0] = itm[i][s][1];
                    cnt[i][s]--;
                end
                if (x[s]) begin
                    itm[i][s][cnt[i][s]] = (s == 0) ? di[i] : fr[s-1];
                    cnt[i][s]++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 3; s++) cnt[i][s] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++)
                    for (int s = 0; s < 3; s++) cnt[i][s] = 0;
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Compare process: outputs vs model every cycle, plus the stall-hold rule.
    bit         prv_stall [2] = '{0, 0};
    logic [7:0] prv_d     [2];

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic       av, ar;
                logic [7:0] ad;
                logic [2:0] au;
                int         n, u;
                n  = ns(i);
                av = (i == 0) ? vo2 : vo3;
                ar = (i == 0) ? ro2 : ro3;
                ad = (i == 0) ? do2 : do3;
                au = (i == 0) ? us2 : us3;
                u  = 0;
                for (int s = 0; s < n; s++) u += cnt[i][s];
                chk($sformatf("ready_o[n%0d]", n), 32'(ar), 32'(!fl[i] && cnt[i][0] < 2));
                chk($sformatf("valid_o[n%0d]", n), 32'(av), 32'(!fl[i] && cnt[i][n-1] > 0));
                chk($sformatf("usage_o[n%0d]", n), 32'(au), 32'(u));
                if (!fl[i] && cnt[i][n-1] > 0)
                    chk($sformatf("data_o[n%0d]", n), 32'(ad), 32'(itm[i][n-1][0]));
                if (rst_n && prv_stall[i] && !fl[i]) begin
                    chk($sformatf("hold_valid[n%0d]", n), 32'(av), 32'd1);
                    chk($sformatf("hold_data[n%0d]", n), 32'(ad), 32'(prv_d[i]));
                end
                prv_stall[i] = rst_n && av && !ri[i] && !fl[i];
                prv_d[i]     = ad;
            end
            chk("bypass_valid", 32'(vob), 32'(vib));
            chk("bypass_ready", 32'(rob), 32'(rib));
            chk("bypass_data",  32'(dob), 32'(dib));
            chk("bypass_usage", 32'(usb), 32'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q [$];
        int         idx;
        bit         seen;

        for (int i = 0; i < 2; i++) begin
            vi[i] = 1'b0; ri[i] = 1'b1; fl[i] = 1'b0; di[i] = 8'h00;
        end
        vib = 1'b0; rib = 1'b0; flb = 1'b0; dib = 8'h00;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ro2), 32'd1);
        chk("rst_valid", 32'(vo2), 32'd0);
        chk("rst_usage", 32'(us2), 32'd0);
        chk("rst_data",  32'(do2), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("post_rst_ready", 32'(ro2), 32'd1);
        chk("post_rst_valid", 32'(vo2), 32'd0);
        chk("post_rst_usage", 32'(us2), 32'd0);

        // Streaming through 3 stages: item driven in cycle c is visible in cycle c+3
        ri[1] = 1'b1;
        for (int c = 0; c < 19; c++) begin
            next_cycle();
            vi[1] = (c < 16);
            di[1] = 8'(c + 1);
            @(negedge clk);
            if (c < 3) chk("stream_early_valid", 32'(vo3), 32'd0);
            else begin
                chk("stream_valid", 32'(vo3), 32'd1);
                chk("stream_data",  32'(do3), 32'(c - 2));
            end
        end
        next_cycle();
        vi[1] = 1'b0;

        // Backpressure on 2 stages: four accepted, fifth held by the source
        ri[0] = 1'b0;
        idx   = 0;
        q     = {};
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if (c == 10) ri[0] = 1'b1;
            vi[0] = (idx < 5);
            di[0] = 8'hA0 + 8'(idx);
            @(negedge clk);
            if (c == 9) begin
                chk("bp_usage",    32'(us2), 32'd4);
                chk("bp_ready",    32'(ro2), 32'd0);
                chk("bp_accepted", 32'(idx), 32'd4);
            end
            if (vo2 && ri[0]) q.push_back(do2);
            if (vi[0] && ro2) idx++;
        end
        chk("bp_out_count", 32'(q.size()), 32'd5);
        for (int k = 0; k < q.size() && k < 5; k++)
            chk("bp_out_order", 32'(q[k]), 32'hA0 + 32'(k));
        next_cycle();
        vi[0] = 1'b0;

        // Flush with three entries held
        ri[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vi[0] = 1'b1;
            di[0] = 8'h31 + 8'(k);
            next_cycle();
        end
        fl[0] = 1'b1; vi[0] = 1'b1; ri[0] = 1'b1; di[0] = 8'h99;
        @(negedge clk);
        chk("flush_usage_before", 32'(us2), 32'd3);
        chk("flush_ready",        32'(ro2), 32'd0);
        chk("flush_valid",        32'(vo2), 32'd0);
        next_cycle();
        fl[0] = 1'b0; vi[0] = 1'b0;
        @(negedge clk);
        chk("after_flush_usage", 32'(us2), 32'd0);
        chk("after_flush_valid", 32'(vo2), 32'd0);
        chk("after_flush_ready", 32'(ro2), 32'd1);
        next_cycle();
        vi[0] = 1'b1; di[0] = 8'h55;
        next_cycle();
        vi[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (vo2) begin
                seen = 1'b1;
                chk("flush_first_item", 32'(do2), 32'h55);
            end
            next_cycle();
        end
        if (!seen) chk("flush_first_item_timeout", 32'd0, 32'd1);

        // Asynchronous reset mid-operation
        ri[1] = 1'b0;
        vi[1] = 1'b1; di[1] = 8'h77;
        next_cycle();
        di[1] = 8'h78;
        next_cycle();
        vi[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_usage", 32'(us3), 32'd0);
        chk("arst_valid", 32'(vo3), 32'd0);
        chk("arst_ready", 32'(ro3), 32'd1);
        next_cycle();
        rst_n = 1'b1;

        // Bypass mirrors inputs, flush ignored
        vib = 1'b1; rib = 1'b0; dib = 8'h5A; flb = 1'b1;
        #1;
        chk("byp_valid", 32'(vob), 32'd1);
        chk("byp_ready", 32'(rob), 32'd0);
        chk("byp_data",  32'(dob), 32'h5A);
        chk("byp_usage", 32'(usb), 32'd0);
        vib = 1'b0; rib = 1'b1; dib = 8'hA5;
        #1;
        chk("byp_valid2", 32'(vob), 32'd0);
        chk("byp_ready2", 32'(rob), 32'd1);
        chk("byp_data2",  32'(dob), 32'hA5);

        // Random traffic; ready bias changes halfway to exercise both full and drained regimes
        for (int c = 0; c < 10000; c++) begin
            next_cycle();
            for (int i = 0; i < 2; i++) begin
                vi[i] = ($urandom_range(0, 3) != 0);
                ri[i] = (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                fl[i] = ($urandom_range(0, 63) == 0);
                di[i] = 8'($urandom);
            end
            vib = 1'($urandom);
            rib = 1'($urandom);
            flb = 1'($urandom);
            dib = 8'($urandom);
        end
        next_cycle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
